alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Issue/writeback stage sitting in front of an external 8-bit combinational ALU.
// Accepts one instruction at a time over a valid/ready handshake, reads its
// operands from a 4-entry register file, drives the ALU for a single EXEC
// cycle, captures the ALU result and offers it downstream on a second
// valid/ready handshake. The register file is written when that result is
// accepted. Only one instruction is ever in flight, so there are no hazards.
//
// Instruction word (DATA_W+8 bits, shown for DATA_W=8):
//   [15] ldi  [14:12] opcode  [11:10] rd  [9:8] rs1  [7:6] rs2  [7:0] imm
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    instruction offered by upstream
//   in_ready    stage can accept an instruction (0 while rst is high)
//   in_instr    instruction word
//   alu_a       ALU operand a (rf[rs1] in EXEC, else 0)
//   alu_b       ALU operand b (rf[rs2] in EXEC, else 0)
//   alu_opcode  ALU opcode (instruction opcode in EXEC, else 0)
//   alu_out     combinational ALU result
//   res_valid   result offered downstream
//   res_ready   downstream accepts the result
//   res_data    result value
//   res_rd      destination register of the result
//   res_zero    res_data == 0
// -----------------------------------------------------------------------------
module alu_issue #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W+7:0] in_instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [1:0]        res_rd,
   output logic              res_zero
);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StWb
   } state_e;

   // Instruction field decode. Field positions are anchored to DATA_W so the
   // immediate always spans the low DATA_W bits.
   logic              instr_ldi;
   logic [2:0]        instr_opcode;
   logic [1:0]        instr_rd;
   logic [1:0]        instr_rs1;
   logic [1:0]        instr_rs2;
   logic [DATA_W-1:0] instr_imm;

   assign instr_ldi    = in_instr[DATA_W+7];
   assign instr_opcode = in_instr[DATA_W+6:DATA_W+4];
   assign instr_rd     = in_instr[DATA_W+3:DATA_W+2];
   assign instr_rs1    = in_instr[DATA_W+1:DATA_W];
   assign instr_rs2    = in_instr[DATA_W-1:DATA_W-2];
   assign instr_imm    = in_instr[DATA_W-1:0];

   state_e            state_q,  state_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [1:0]        rd_q,     rd_d;
   logic [1:0]        rs1_q,    rs1_d;
   logic [1:0]        rs2_q,    rs2_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] rf_q [4];
   logic [DATA_W-1:0] rf_d [4];

   logic              in_fire;
   logic              res_fire;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   // in_ready is gated by rst so upstream never sees a transfer that reset
   // would immediately throw away.
   assign in_ready  = (state_q == StIdle) && !rst;
   assign in_fire   = in_valid && in_ready;
   assign res_valid = (state_q == StWb);
   assign res_fire  = res_valid && res_ready;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      result_d = result_q;
      rf_d     = rf_q;

      unique case (state_q)
         StIdle: begin
            if (in_fire) begin
               opcode_d = instr_opcode;
               rd_d     = instr_rd;
               rs1_d    = instr_rs1;
               rs2_d    = instr_rs2;
               if (instr_ldi) begin
                  // Load-immediate bypasses the ALU entirely.
                  result_d = instr_imm;
                  state_d  = StWb;
               end else begin
                  state_d  = StExec;
               end
            end
         end

         StExec: begin
            result_d = alu_out;
            state_d  = StWb;
         end

         StWb: begin
            if (res_fire) begin
               rf_d[rd_q] = result_q;
               state_d    = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers (synchronous reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         opcode_q <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         result_q <= '0;
         for (int i = 0; i < 4; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         result_q <= result_d;
         rf_q     <= rf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The ALU is only driven during EXEC; opcode 7 ignores b but rf[rs2] is
   // still presented.
   assign alu_a      = (state_q == StExec) ? rf_q[rs1_q] : '0;
   assign alu_b      = (state_q == StExec) ? rf_q[rs2_q] : '0;
   assign alu_opcode = (state_q == StExec) ? opcode_q    : 3'd0;

   // The result registers only change on accept/EXEC, so these stay stable
   // for as long as WB is stalled.
   assign res_data = result_q;
   assign res_rd   = rd_q;
   assign res_zero = (result_q == '0);

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Directed self-checking bench for alu_issue. Contains a behavioural model of
// the downstream 8-bit combinational ALU, drives directed instruction
// sequences and compares against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_issue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_out;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [1:0]  res_rd;
   logic        res_zero;

   int checks;
   int errors;

   alu_issue #(
      .DATA_W(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_opcode(alu_opcode),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_rd    (res_rd),
      .res_zero  (res_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU
   always_comb begin
      alu_out = 8'h00;
      case (alu_opcode)
         3'd0: alu_out = alu_a + alu_b;
         3'd1: alu_out = alu_a - alu_b;
         3'd2: alu_out = alu_a & alu_b;
         3'd3: alu_out = ~(alu_a | alu_b);
         3'd4: alu_out = alu_a | alu_b;
         3'd5: alu_out = ~(alu_a & alu_b);
         3'd6: alu_out = alu_a ^ alu_b;
         default: alu_out = ~alu_a;
      endcase
   end

   function automatic logic [15:0] enc_op(input logic [2:0] opc, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
      return {1'b0, opc, rd, rs1, rs2, 6'b000000};
   endfunction

   function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {1'b1, 3'b000, rd, 2'b00, imm};
   endfunction

   // Issues one instruction (res_ready assumed 1), captures the ALU drive in the
   // first cycle after accept and the result when res_valid first rises, then
   // completes the writeback. lat = cycles from accept to res_valid, -1 if the
   // instruction was never accepted. Returns at the negedge after writeback.
   task automatic run_op(input logic [15:0] instr, output logic [7:0] a, output logic [7:0] b,
                         output logic [2:0] opc, output logic [7:0] d, output logic [1:0] rd,
                         output logic z, output int lat);
      int n;
      lat = -1;
      a = '0; b = '0; opc = '0; d = '0; rd = '0; z = 1'b0;
      in_instr = instr;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      a   = alu_a;
      b   = alu_b;
      opc = alu_opcode;
      lat = 1;
      while (!res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      d  = res_data;
      rd = res_rd;
      z  = res_zero;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready); errors++;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready_after: got %b want 1", in_ready); errors++;
      end
      checks++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || res_rd !== 2'd0 || res_zero !== 1'b1) begin
         $display("FAIL reset_res: got v=%b d=%h rd=%0d z=%b want v=0 d=00 rd=0 z=1",
                  res_valid, res_data, res_rd, res_zero); errors++;
      end
      checks++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_opcode !== 3'd0) begin
         $display("FAIL reset_alu: got a=%h b=%h op=%0d want 0/0/0", alu_a, alu_b, alu_opcode);
         errors++;
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      run_op(enc_ldi(2'd1, 8'd20), a, b, opc, d, rd, z, lat);
      checks++;
      if (lat !== 1 || d !== 8'd20 || rd !== 2'd1 || a !== 8'h00) begin
         $display("FAIL ldi_r1_20: got lat=%0d d=%0d rd=%0d a=%h want 1/20/1/00", lat, d, rd, a);
         errors++;
      end
      run_op(enc_ldi(2'd2, 8'd10), a, b, opc, d, rd, z, lat);
      checks++;
      if (lat !== 1 || d !== 8'd10 || rd !== 2'd2) begin
         $display("FAIL ldi_r2_10: got lat=%0d d=%0d rd=%0d want 1/10/2", lat, d, rd); errors++;
      end
      run_op(enc_op(3'd0, 2'd3, 2'd1, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd20 || b !== 8'd10 || opc !== 3'd0) begin
         $display("FAIL add_exec_drive: got a=%0d b=%0d op=%0d want 20/10/0", a, b, opc);
         errors++;
      end
      checks++;
      if (lat !== 2 || d !== 8'd30 || rd !== 2'd3 || z !== 1'b0) begin
         $display("FAIL add_result: got lat=%0d d=%0d rd=%0d z=%b want 2/30/3/0", lat, d, rd, z);
         errors++;
      end
      checks++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
         $display("FAIL add_return_idle: got rdy=%b v=%b want 1/0", in_ready, res_valid);
         errors++;
      end
      checks++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_opcode !== 3'd0) begin
         $display("FAIL alu_idle_zero: got a=%h b=%h op=%0d want 0/0/0", alu_a, alu_b, alu_opcode);
         errors++;
      end
   endtask

   task automatic test_wrap();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      run_op(enc_op(3'd1, 2'd0, 2'd2, 2'd1), a, b, opc, d, rd, z, lat);
      checks++;
      if (d !== 8'd246 || rd !== 2'd0 || a !== 8'd10 || b !== 8'd20) begin
         $display("FAIL sub_wrap: got d=%0d rd=%0d a=%0d b=%0d want 246/0/10/20", d, rd, a, b);
         errors++;
      end
      run_op(enc_ldi(2'd1, 8'd200), a, b, opc, d, rd, z, lat);
      run_op(enc_ldi(2'd2, 8'd100), a, b, opc, d, rd, z, lat);
      run_op(enc_op(3'd0, 2'd3, 2'd1, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (d !== 8'd44 || rd !== 2'd3) begin
         $display("FAIL add_wrap: got d=%0d rd=%0d want 44/3", d, rd); errors++;
      end
      run_op(enc_op(3'd7, 2'd3, 2'd1, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (d !== 8'd55 || a !== 8'd200 || b !== 8'd100 || opc !== 3'd7) begin
         $display("FAIL not_a: got d=%0d a=%0d b=%0d op=%0d want 55/200/100/7", d, a, b, opc);
         errors++;
      end
   endtask

   task automatic test_zero();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      run_op(enc_op(3'd6, 2'd2, 2'd1, 2'd1), a, b, opc, d, rd, z, lat);
      checks++;
      if (d !== 8'd0 || z !== 1'b1 || rd !== 2'd2) begin
         $display("FAIL xor_zero: got d=%0d z=%b rd=%0d want 0/1/2", d, z, rd); errors++;
      end
      run_op(enc_op(3'd4, 2'd0, 2'd2, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd0 || b !== 8'd0 || d !== 8'd0 || z !== 1'b1) begin
         $display("FAIL or_reads_new_r2: got a=%0d b=%0d d=%0d z=%b want 0/0/0/1", a, b, d, z);
         errors++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      // rf now: r0=0 r1=200 r2=0 r3=55
      res_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL bp_start_ready: got %b want 1", in_ready); errors++;
      end
      in_instr = enc_op(3'd0, 2'd0, 2'd1, 2'd3);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_data !== 8'd255 || res_rd !== 2'd0 || in_ready !== 1'b0)
         begin
            $display("FAIL bp_hold_%0d: got v=%b d=%0d rd=%0d rdy=%b want 1/255/0/0",
                     i, res_valid, res_data, res_rd, in_ready); errors++;
         end
         // Offer an instruction while stalled; it must be ignored.
         if (i == 1) begin
            in_instr = enc_ldi(2'd1, 8'd7);
            in_valid = 1'b1;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
         $display("FAIL bp_release: got rdy=%b v=%b want 1/0", in_ready, res_valid); errors++;
      end
      // r0 written with 255, r1 untouched by the ignored ldi.
      run_op(enc_op(3'd4, 2'd1, 2'd0, 2'd1), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd255 || b !== 8'd200 || d !== 8'd255) begin
         $display("FAIL bp_rf_after: got a=%0d b=%0d d=%0d want 255/200/255", a, b, d); errors++;
      end
   endtask

   task automatic test_reset_exec();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      // r1=255; add r2=r1+r1 aborted in EXEC
      in_instr = enc_op(3'd0, 2'd2, 2'd1, 2'd1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (alu_a !== 8'd255 || res_valid !== 1'b0) begin
         $display("FAIL rexec_in_exec: got a=%0d v=%b want 255/0", alu_a, res_valid); errors++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_zero !== 1'b1 || res_data !== 8'd0 ||
          alu_a !== 8'd0) begin
         $display("FAIL rexec_after: got v=%b rdy=%b z=%b d=%0d a=%0d want 0/1/1/0/0",
                  res_valid, in_ready, res_zero, res_data, alu_a); errors++;
      end
      @(negedge clk);
      run_op(enc_op(3'd6, 2'd0, 2'd1, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd0 || b !== 8'd0 || d !== 8'd0) begin
         $display("FAIL rexec_rf_r1r2: got a=%0d b=%0d d=%0d want 0/0/0", a, b, d); errors++;
      end
      run_op(enc_op(3'd6, 2'd0, 2'd3, 2'd0), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd0 || b !== 8'd0) begin
         $display("FAIL rexec_rf_r3r0: got a=%0d b=%0d want 0/0", a, b); errors++;
      end
   endtask

   task automatic test_reset_wb();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      run_op(enc_ldi(2'd3, 8'd9), a, b, opc, d, rd, z, lat);
      res_ready = 1'b0;
      in_instr  = enc_ldi(2'd2, 8'd77);
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'd77 || res_rd !== 2'd2) begin
         $display("FAIL rwb_stalled: got v=%b d=%0d rd=%0d want 1/77/2",
                  res_valid, res_data, res_rd); errors++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      res_ready = 1'b1;
      #1;
      checks++;
      if (res_valid !== 1'b0 || res_data !== 8'd0 || in_ready !== 1'b1) begin
         $display("FAIL rwb_after: got v=%b d=%0d rdy=%b want 0/0/1", res_valid, res_data, in_ready);
         errors++;
      end
      @(negedge clk);
      run_op(enc_op(3'd6, 2'd0, 2'd3, 2'd2), a, b, opc, d, rd, z, lat);
      checks++;
      if (a !== 8'd0 || b !== 8'd0) begin
         $display("FAIL rwb_rf_clear: got a=%0d b=%0d want 0/0", a, b); errors++;
      end
   endtask

   task automatic test_sweep();
      logic [7:0] a, b, d;
      logic [2:0] opc;
      logic [1:0] rd;
      logic       z;
      int         lat;
      logic [7:0] exp_tab [8];
      exp_tab[0] = 8'hE1; exp_tab[1] = 8'h69; exp_tab[2] = 8'h24; exp_tab[3] = 8'h42;
      exp_tab[4] = 8'hBD; exp_tab[5] = 8'hDB; exp_tab[6] = 8'h99; exp_tab[7] = 8'h5A;
      run_op(enc_ldi(2'd1, 8'hA5), a, b, opc, d, rd, z, lat);
      run_op(enc_ldi(2'd2, 8'h3C), a, b, opc, d, rd, z, lat);
      for (int i = 0; i < 8; i++) begin
         run_op(enc_op(3'(i), 2'd3, 2'd1, 2'd2), a, b, opc, d, rd, z, lat);
         checks++;
         if (d !== exp_tab[i] || a !== 8'hA5 || b !== 8'h3C || opc !== 3'(i) || lat !== 2) begin
            $display("FAIL sweep_op%0d: got d=%h a=%h b=%h op=%0d lat=%0d want %h/A5/3C/%0d/2",
                     i, d, a, b, opc, lat, exp_tab[i], i); errors++;
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      res_ready = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_zero();
      test_backpressure();
      test_reset_exec();
      test_reset_wb();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
